// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM state encoding and the fixed APB data width.
package apb_pkg;

    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating ACCESS-phase wait counter. Flags the wait cycle whose increment reaches LIMIT.
module apb_timeout_cnt #(
    parameter int LIMIT = 255
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero limit means the timeout is disabled entirely.
    assign expired = (LIMIT != 0) && enable && !clear && (cnt_d == LIMIT_C);

endmodule

// File: rtl/apb_req_master.sv
// Request/response to APB master bridge: one transfer outstanding, registered APB and response outputs.
module apb_req_master
    import apb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr,
    input  logic [APB_DATA_W-1:0]     req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [APB_DATA_W-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [APB_DATA_W-1:0]     PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [APB_DATA_W-1:0]     PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    apb_state_e                state_q, state_d;
    logic                      req_ready_q, req_ready_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [APB_DATA_W-1:0]     pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [APB_DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q, rsp_err_d;
    logic                      rsp_timeout_q, rsp_timeout_d;

    logic cnt_clear;
    logic cnt_enable;
    logic cnt_expired;

    // Counter is zeroed during SETUP so it starts from 0 in the first ACCESS cycle.
    assign cnt_clear  = (state_q == ST_SETUP);
    assign cnt_enable = (state_q == ST_ACCESS) && !PREADY;

    apb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (cnt_expired)
    );

    always_comb begin
        state_d       = state_q;
        req_ready_d   = req_ready_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d     = ST_SETUP;
                    req_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    paddr_d     = {req_addr[APB_ADDR_WIDTH-1:2], 2'b00};
                    pwdata_d    = req_wdata;
                    pwrite_d    = req_write;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                // A completer response on the limit cycle takes priority over the timeout.
                if (PREADY) begin
                    state_d       = ST_RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else if (cnt_expired) begin
                    state_d       = ST_RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d       = ST_IDLE;
                    req_ready_d   = 1'b1;
                    rsp_valid_d   = 1'b0;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pwrite_q      <= pwrite_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PWRITE      = pwrite_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Directed bench for apb_req_master: completer driven inline, responses checked against a queue scoreboard.
module tb_apb_req_master;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    rsp_t exp_q[$];

    apb_req_master #(
        .APB_ADDR_WIDTH (12),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PWRITE      (PWRITE),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle again.
    task automatic do_xfer(input string name, input logic wr, input logic [11:0] addr,
                           input logic [31:0] wdata, input int waits, input logic hang,
                           input logic [31:0] prdata, input logic slverr, input int hold);
        rsp_t        e;
        rsp_t        g;
        logic [11:0] exp_paddr;
        int          acc;
        int          exp_acc;

        exp_paddr = {addr[11:2], 2'b00};
        e.rdata   = (wr || hang) ? 32'h0 : prdata;
        e.err     = hang || slverr;
        e.to      = hang;
        exp_acc   = hang ? 4 : waits + 1;

        chk1("idle_req_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        exp_q.push_back(e);

        @(negedge HCLK);
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = 12'($urandom);
        req_wdata = $urandom;
        chk1("setup_psel", PSEL, 1'b1);
        chk1("setup_penable", PENABLE, 1'b0);
        chk1("setup_req_ready", req_ready, 1'b0);
        chk32("setup_paddr", 32'(PADDR), 32'(exp_paddr));
        chk32("setup_pwdata", PWDATA, wdata);
        chk1("setup_pwrite", PWRITE, wr);

        @(negedge HCLK);
        acc = 0;
        while (rsp_valid !== 1'b1 && acc < 20) begin
            chk1("acc_psel", PSEL, 1'b1);
            chk1("acc_penable", PENABLE, 1'b1);
            chk32("acc_paddr", 32'(PADDR), 32'(exp_paddr));
            chk32("acc_pwdata", PWDATA, wdata);
            chk1("acc_pwrite", PWRITE, wr);
            if (!hang && acc == waits) begin
                PREADY  = 1'b1;
                PRDATA  = prdata;
                PSLVERR = slverr;
            end else begin
                PREADY  = 1'b0;
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom);
            end
            acc++;
            @(negedge HCLK);
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            PRDATA  = $urandom;
        end
        chk32("access_cycles", 32'(acc), 32'(exp_acc));

        chk1("resp_valid", rsp_valid, 1'b1);
        chk1("resp_psel", PSEL, 1'b0);
        chk1("resp_penable", PENABLE, 1'b0);
        chk1("resp_req_ready", req_ready, 1'b0);
        checks++;
        assert (exp_q.size() > 0) else begin
            failures++;
            $error("FAIL sb_pop observed=empty expected=entry");
        end
        if (exp_q.size() > 0) begin
            g = exp_q.pop_front();
            chk32("rsp_rdata", rsp_rdata, g.rdata);
            chk1("rsp_err", rsp_err, g.err);
            chk1("rsp_timeout", rsp_timeout, g.to);
        end

        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_write = 1'($urandom);
            req_addr  = 12'($urandom);
            @(negedge HCLK);
            chk1("hold_valid", rsp_valid, 1'b1);
            chk1("hold_req_ready", req_ready, 1'b0);
            chk1("hold_psel", PSEL, 1'b0);
            chk32("hold_rdata", rsp_rdata, e.rdata);
            chk1("hold_err", rsp_err, e.err);
            chk1("hold_timeout", rsp_timeout, e.to);
        end

        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge HCLK);
        rsp_ready = 1'b0;
        chk1("done_valid", rsp_valid, 1'b0);
        chk1("done_req_ready", req_ready, 1'b1);
        chk1("done_psel", PSEL, 1'b0);
        $display("XFER %s wr=%0b addr=0x%03h access_cycles=%0d rdata=0x%08h err=%0b timeout=%0b",
                 name, wr, addr, acc, e.rdata, e.err, e.to);
    endtask

    initial begin
        repeat (2) @(negedge HCLK);
        chk1("rst_psel", PSEL, 1'b0);
        chk1("rst_penable", PENABLE, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk32("rst_paddr", 32'(PADDR), 32'h0);
        chk32("rst_pwdata", PWDATA, 32'h0);
        chk1("rst_pwrite", PWRITE, 1'b0);
        chk32("rst_rdata", rsp_rdata, 32'h0);
        chk1("rst_err", rsp_err, 1'b0);
        chk1("rst_timeout", rsp_timeout, 1'b0);
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk1("post_rst_req_ready", req_ready, 1'b1);

        do_xfer("rd_zero_wait", 1'b0, 12'h00C, 32'h0, 0, 1'b0, 32'hA5A5_0001, 1'b0, 0);
        do_xfer("wr_3_wait", 1'b1, 12'h013, 32'h0000_00FF, 3, 1'b0, 32'hFFFF_FFFF, 1'b0, 0);
        do_xfer("rd_slverr", 1'b0, 12'h124, 32'h0, 1, 1'b0, 32'hDEAD_BEEF, 1'b1, 0);
        do_xfer("rd_timeout", 1'b0, 12'h200, 32'h0, 0, 1'b1, 32'h1234_5678, 1'b0, 0);
        do_xfer("wr_held_rsp", 1'b1, 12'hFFF, 32'hCAFE_F00D, 2, 1'b0, 32'h5555_AAAA, 1'b1, 10);
        do_xfer("rd_after_hold", 1'b0, 12'h7FC, 32'h0, 0, 1'b0, 32'h0BAD_F00D, 1'b0, 0);

        // Reset in the middle of an ACCESS phase discards the transfer.
        chk1("mid_req_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 12'h344;
        req_wdata = 32'h1234_5678;
        @(negedge HCLK);
        req_valid = 1'b0;
        chk1("mid_setup_psel", PSEL, 1'b1);
        @(negedge HCLK);
        chk1("mid_access_penable", PENABLE, 1'b1);
        PREADY = 1'b0;
        #2;
        HRESETn = 1'b0;
        #1;
        chk1("mid_rst_psel", PSEL, 1'b0);
        chk1("mid_rst_penable", PENABLE, 1'b0);
        chk1("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk32("mid_rst_paddr", 32'(PADDR), 32'h0);
        chk32("mid_rst_pwdata", PWDATA, 32'h0);
        chk1("mid_rst_pwrite", PWRITE, 1'b0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk1("mid_post_req_ready", req_ready, 1'b1);
        chk1("mid_post_rsp_valid", rsp_valid, 1'b0);
        chk1("mid_post_psel", PSEL, 1'b0);
        $display("XFER mid_access_reset discarded");

        do_xfer("rd_after_reset", 1'b0, 12'h0A8, 32'h0, 1, 1'b0, 32'h600D_0001, 1'b0, 0);

        chk32("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

endmodule

// File: doc/apb_req_master.md
APB_REQ_MASTER -- requirements
Module: apb_req_master

Interface
REQ-001 Parameter APB_ADDR_WIDTH, default 12, width of PADDR and req_addr.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, maximum ACCESS-phase wait cycles; 0 disables timeout.
REQ-003 HCLK  in  1  clock; all logic on rising edge.
REQ-004 HRESETn  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  transfer request present.
REQ-006 req_ready  out  1  request accepted when req_valid & req_ready.
REQ-007 req_write  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  APB_ADDR_WIDTH  byte address.
REQ-009 req_wdata  in  32  write data.
REQ-010 rsp_valid  out  1  response present.
REQ-011 rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
REQ-012 rsp_rdata  out  32  read data; 0 for writes and timeouts.
REQ-013 rsp_err  out  1  PSLVERR seen or timeout.
REQ-014 rsp_timeout  out  1  transfer ended by timeout.
REQ-015 PADDR  out  APB_ADDR_WIDTH; PWDATA  out  32; PWRITE  out  1; PSEL  out  1; PENABLE  out  1  APB master outputs.
REQ-016 PRDATA  in  32; PREADY  in  1; PSLVERR  in  1  APB completer inputs.

Function
REQ-017 FSM states IDLE, SETUP, ACCESS, RESP; one transfer outstanding at a time.
REQ-018 IDLE: req_ready=1, PSEL=0, PENABLE=0; on req_valid capture write/addr/wdata, go SETUP.
REQ-019 All other states: req_ready=0; req_* inputs ignored.
REQ-020 SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then ACCESS.
REQ-021 ACCESS: PSEL=1, PENABLE=1 until PREADY=1 or timeout.
REQ-022 PADDR, PWRITE, PWDATA driven from captured registers, stable from SETUP through last ACCESS cycle.
REQ-023 PADDR[1:0] forced to 0 (word-aligned); upper bits from req_addr.
REQ-024 ACCESS with PREADY=1: rsp_rdata=PRDATA if read else 0, rsp_err=PSLVERR, rsp_timeout=0, go RESP.
REQ-025 Wait counter cleared on entering ACCESS, incremented each ACCESS cycle with PREADY=0.
REQ-026 Counter reaching TIMEOUT_CYCLES (nonzero) with PREADY=0: go RESP, rsp_err=1, rsp_timeout=1, rsp_rdata=0; PREADY on that same cycle wins over timeout.
REQ-027 Counter width $clog2(TIMEOUT_CYCLES+1), saturating, never wraps.
REQ-028 RESP: PSEL=0, PENABLE=0, rsp_valid=1, response fields held stable until rsp_ready=1, then IDLE.
REQ-029 Latency: accept at cycle T, SETUP T+1, ACCESS T+2; PREADY at T+2 gives rsp_valid at T+3.
REQ-030 Minimum one IDLE cycle between transfers; throughput one transfer per 4 cycles at zero wait states.
REQ-031 PSEL never asserted outside SETUP/ACCESS; PENABLE never asserted without PSEL.

Reset
REQ-032 On HRESETn low, mid-transfer included: state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, counter=0; in-flight transfer discarded with no response.
REQ-033 req_ready=1 in the first cycle after reset release.

Structure
REQ-034 Shared package apb_pkg holds state enum (IDLE/SETUP/ACCESS/RESP) and 32-bit APB data width constant.
REQ-035 One sub-module apb_timeout_cnt (clear, enable, parameterised limit, expired flag); remainder flat.

Verification
REQ-036 Read, addr 0x00C, completer PREADY=1 immediately, PRDATA=0xA5A5_0001 -> PSEL/PENABLE at T+1/T+2, rsp_valid T+3, rsp_rdata=0xA5A5_0001, rsp_err=0.
REQ-037 Write, addr 0x013, wdata 0x0000_00FF, PREADY after 3 wait states -> PADDR=0x010, PWDATA stable 5 cycles, rsp_rdata=0, rsp_err=0.
REQ-038 Read with PSLVERR=1 at completion -> rsp_err=1, rsp_timeout=0, state back to IDLE after rsp_ready.
REQ-039 TIMEOUT_CYCLES=4, PREADY held 0 -> PSEL drops after 4 wait cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-040 rsp_ready held 0 for 10 cycles with req_valid=1 -> req_ready=0, response stable, no new SETUP; rsp_ready=1 -> IDLE next cycle, next request accepted.
REQ-041 HRESETn asserted during ACCESS -> PSEL=0, PENABLE=0, rsp_valid=0 immediately; req_ready=1 after release.
